turn_arbiter: RTL and testbench

Sequencer that sits between the six player Pmod inputs and the game core. It synchronizes each player's asynchronous submit strobe and captures that player's 3-bit value. It then arbitrates pending submissions and delivers them one at a time to the game over a valid/ready handshake. Two policies are supported: round-robin free-for-all and strict turn order.

---
 rtl/game_pkg.sv | 14 +
 rtl/strobe_sync.sv | 41 ++++
 rtl/turn_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_turn_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the player-input front end of the game.
package game_pkg;

    localparam int N_PLAYERS = 6;
    localparam int VAL_W     = 3;
    localparam int IDX_W     = 3;

    // Handshake FSM of the submission arbiter.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer for one player's submit strobe and value bits,
// plus rising-edge detection on the synchronized strobe.
module strobe_sync #(
    parameter int VAL_W = game_pkg::VAL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic [VAL_W-1:0] val,
    output logic             rise,
    output logic [VAL_W-1:0] val_sync
);

    logic             strobe_s1;
    logic             strobe_s2;
    logic             strobe_prev;
    logic [VAL_W-1:0] val_s1;
    logic [VAL_W-1:0] val_s2;

    // Both synchronizer stages and the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_s1   <= 1'b0;
            strobe_s2   <= 1'b0;
            strobe_prev <= 1'b0;
            val_s1      <= '0;
            val_s2      <= '0;
        end else begin
            strobe_s1   <= strobe;
            strobe_s2   <= strobe_s1;
            strobe_prev <= strobe_s2;
            val_s1      <= val;
            val_s2      <= val_s1;
        end
    end

    // The value travels alongside the strobe, so it is valid when rise fires.
    assign rise     = strobe_s2 & ~strobe_prev;
    assign val_sync = val_s2;

endmodule

// File: rtl/turn_arbiter.sv
// Collects player submissions into per-player pending/hold registers and
// hands them to the game core one at a time, either round-robin or in
// strict turn order.
//
// Handshake: sub_valid is a registered function of the FSM state only.
// While sub_valid is high, sub_player/sub_val are held stable; a transfer
// happens on any clock edge where sub_valid & sub_ready are both high.
// sub_ready may be high before sub_valid and never feeds sub_valid
// combinationally.
module turn_arbiter #(
    parameter int N_PLAYERS = game_pkg::N_PLAYERS,
    parameter int VAL_W     = game_pkg::VAL_W,
    parameter int IDX_W     = game_pkg::IDX_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PLAYERS-1:0]       player_strobe,
    input  logic [N_PLAYERS*VAL_W-1:0] player_val,
    input  logic [N_PLAYERS-1:0]       active_mask,
    input  logic                       mode,
    output logic                       sub_valid,
    output logic [IDX_W-1:0]           sub_player,
    output logic [VAL_W-1:0]           sub_val,
    input  logic                       sub_ready,
    output logic [IDX_W-1:0]           turn,
    output logic [N_PLAYERS-1:0]       pending,
    output logic                       overrun
);

    import game_pkg::arb_state_t;
    import game_pkg::ARB_IDLE;
    import game_pkg::ARB_GRANT;

    // Next index after c, wrapping modulo N_PLAYERS.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] c);
        return (c == IDX_W'(N_PLAYERS - 1)) ? '0 : c + 1'b1;
    endfunction

    // First set bit of mask strictly after 'from', wrapping; returns {found, index}.
    function automatic logic [IDX_W:0] next_active(input logic [IDX_W-1:0]     from,
                                                   input logic [N_PLAYERS-1:0] mask);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] res;
        logic             found;
        cand  = from;
        res   = from;
        found = 1'b0;
        for (int k = 0; k < N_PLAYERS; k++) begin
            cand = wrap_inc(cand);
            if (!found && mask[cand]) begin
                found = 1'b1;
                res   = cand;
            end
        end
        return {found, res};
    endfunction

    logic [N_PLAYERS-1:0] rise;
    logic [VAL_W-1:0]     val_sync [N_PLAYERS];
    logic [VAL_W-1:0]     hold     [N_PLAYERS];

    arb_state_t           state;
    arb_state_t           state_next;
    logic [IDX_W-1:0]     rr_ptr;
    logic [N_PLAYERS-1:0] eligible;
    logic [IDX_W:0]       rr_search;
    logic [IDX_W:0]       turn_skip;
    logic [IDX_W:0]       turn_after;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic                 do_grant;
    logic                 transfer;
    logic [N_PLAYERS-1:0] pending_next;
    logic [N_PLAYERS-1:0] hold_load;
    logic                 overrun_set;

    genvar g;
    generate
        for (g = 0; g < N_PLAYERS; g++) begin : g_sync
            strobe_sync #(.VAL_W(VAL_W)) u_sync (
                .clk      (clk),
                .reset    (reset),
                .strobe   (player_strobe[g]),
                .val      (player_val[g*VAL_W +: VAL_W]),
                .rise     (rise[g]),
                .val_sync (val_sync[g])
            );
        end
    endgenerate

    assign eligible   = pending & active_mask;
    assign rr_search  = next_active(rr_ptr, eligible);
    assign turn_skip  = next_active(turn, active_mask);
    assign turn_after = next_active(sub_player, active_mask);
    assign transfer   = (state == ARB_GRANT) && sub_ready;
    assign do_grant   = (state == ARB_IDLE) && grant_found;

    // Winner selection: round-robin after rr_ptr, or only the current turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (mode) begin
            grant_found = eligible[turn];
            grant_idx   = turn;
        end else begin
            grant_found = rr_search[IDX_W];
            grant_idx   = rr_search[IDX_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_next;
    end

    // FSM next state: grant from IDLE, return to IDLE on transfer.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (grant_found) state_next = ARB_GRANT;
            ARB_GRANT: if (sub_ready)   state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    // FSM outputs: valid is asserted for the whole GRANT state.
    always_comb begin
        sub_valid = (state == ARB_GRANT);
    end

    // Pending/hold update: a new edge on the transfer cycle beats the clear.
    always_comb begin
        pending_next = pending;
        hold_load    = '0;
        overrun_set  = 1'b0;
        if (transfer) pending_next[sub_player] = 1'b0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (rise[i] && active_mask[i]) begin
                if (!pending[i] || (transfer && sub_player == IDX_W'(i))) begin
                    pending_next[i] = 1'b1;
                    hold_load[i]    = 1'b1;
                end else begin
                    overrun_set = 1'b1;
                end
            end
        end
        pending_next = pending_next & active_mask;
    end

    // Pending flags, captured values and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) hold[i] <= '0;
        end else begin
            pending <= pending_next;
            if (overrun_set) overrun <= 1'b1;
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (hold_load[i]) hold[i] <= val_sync[i];
            end
        end
    end

    // Grant data, round-robin pointer and turn tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_player <= '0;
            sub_val    <= '0;
            rr_ptr     <= IDX_W'(N_PLAYERS - 1);
            turn       <= '0;
        end else begin
            if (do_grant) begin
                sub_player <= grant_idx;
                sub_val    <= hold[grant_idx];
            end
            if (transfer) begin
                rr_ptr <= sub_player;
                if (mode && turn_after[IDX_W]) turn <= turn_after[IDX_W-1:0];
            end else if (state == ARB_IDLE && mode && !active_mask[turn] && turn_skip[IDX_W]) begin
                turn <= turn_skip[IDX_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_turn_arbiter.sv
// Self-checking bench for turn_arbiter: scenario tasks with a scoreboard
// queue of expected {player, value} submissions.
`timescale 1ns/1ps
module tb_turn_arbiter;

    logic        clk;
    logic        reset;
    logic [5:0]  player_strobe;
    logic [17:0] player_val;
    logic [5:0]  active_mask;
    logic        mode;
    logic        sub_valid;
    logic [2:0]  sub_player;
    logic [2:0]  sub_val;
    logic        sub_ready;
    logic [2:0]  turn;
    logic [5:0]  pending;
    logic        overrun;

    logic [5:0]  exp_q[$];
    logic [5:0]  exp_item;
    int          checks = 0;
    int          errors = 0;

    turn_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .player_strobe (player_strobe),
        .player_val    (player_val),
        .active_mask   (active_mask),
        .mode          (mode),
        .sub_valid     (sub_valid),
        .sub_player    (sub_player),
        .sub_val       (sub_val),
        .sub_ready     (sub_ready),
        .turn          (turn),
        .pending       (pending),
        .overrun       (overrun)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] pv(input int p, input logic [2:0] v);
        logic [17:0] r;
        r = '0;
        r[p*3 +: 3] = v;
        return r;
    endfunction

    // Driver tasks
    task automatic do_reset();
        reset         = 1'b1;
        player_strobe = '0;
        player_val    = '0;
        active_mask   = 6'h3F;
        mode          = 1'b0;
        sub_ready     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Raises the strobes in m for one cycle; returns at the negedge after E0.
    task automatic pulse(input logic [5:0] m, input logic [17:0] v);
        player_val    = v;
        player_strobe = m;
        @(negedge clk);
        player_strobe = '0;
    endtask

    task automatic wait_valid(input int budget, output bit got);
        int c;
        c = 0;
        while (!sub_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        got = sub_valid;
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        checks++; if (sub_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", sub_valid); end
        checks++; if (sub_player !== 3'd0) begin errors++; $display("FAIL reset_player: got %0d want 0", sub_player); end
        checks++; if (sub_val !== 3'd0) begin errors++; $display("FAIL reset_val: got %0d want 0", sub_val); end
        checks++; if (turn !== 3'd0) begin errors++; $display("FAIL reset_turn: got %0d want 0", turn); end
        checks++; if (pending !== 6'd0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    endtask

    task automatic test_single();
        do_reset();
        exp_q.push_back({3'd2, 3'd5});
        pulse(6'b000100, pv(2, 3'd5));
        repeat (2) @(negedge clk);
        checks++; if (sub_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", sub_valid); end
        checks++; if (pending !== 6'b000100) begin errors++; $display("FAIL single_pending: got %b want 000100", pending); end
        @(negedge clk);
        checks++; if (sub_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got %0b want 1", sub_valid); end
        exp_item = exp_q.pop_front();
        checks++; if ({sub_player, sub_val} !== exp_item) begin errors++; $display("FAIL single_data: got p%0d v%0d want p%0d v%0d", sub_player, sub_val, exp_item[5:3], exp_item[2:0]); end
        @(negedge clk);
        checks++; if (sub_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %0b want 0", sub_valid); end
        checks++; if (pending !== 6'b0) begin errors++; $display("FAIL single_pending_clr: got %b want 0", pending); end
    endtask

    task automatic test_round_robin();
        do_reset();
        exp_q.push_back({3'd0, 3'd1});
        exp_q.push_back({3'd3, 3'd2});
        exp_q.push_back({3'd5, 3'd4});
        pulse(6'b101001, pv(0, 3'd1) | pv(3, 3'd2) | pv(5, 3'd4));
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (sub_valid !== 1'b1) begin errors++; $display("FAIL rr_valid%0d: got %0b want 1", k, sub_valid); end
            exp_item = exp_q.pop_front();
            checks++; if ({sub_player, sub_val} !== exp_item) begin errors++; $display("FAIL rr_data%0d: got p%0d v%0d want p%0d v%0d", k, sub_player, sub_val, exp_item[5:3], exp_item[2:0]); end
            @(negedge clk);
            checks++; if (sub_valid !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: got %0b want 0", k, sub_valid); end
        end
        checks++; if (pending !== 6'b0) begin errors++; $display("FAIL rr_pending: got %b want 0", pending); end
    endtask

    task automatic test_strict();
        bit got;
        do_reset();
        mode = 1'b1;
        pulse(6'b000010, pv(1, 3'd7));
        repeat (4) @(negedge clk);
        checks++; if (sub_valid !== 1'b0) begin errors++; $display("FAIL strict_no_grant: got %0b want 0", sub_valid); end
        checks++; if (pending !== 6'b000010) begin errors++; $display("FAIL strict_pending: got %b want 000010", pending); end
        exp_q.push_back({3'd0, 3'd2});
        exp_q.push_back({3'd1, 3'd7});
        pulse(6'b000001, pv(0, 3'd2));
        wait_valid(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL strict_grant0_timeout: got %0b want 1", got); end
        exp_item = exp_q.pop_front();
        checks++; if ({sub_player, sub_val} !== exp_item) begin errors++; $display("FAIL strict_data0: got p%0d v%0d want p%0d v%0d", sub_player, sub_val, exp_item[5:3], exp_item[2:0]); end
        @(negedge clk);
        checks++; if (turn !== 3'd1) begin errors++; $display("FAIL strict_turn1: got %0d want 1", turn); end
        @(negedge clk);
        checks++; if (sub_valid !== 1'b1) begin errors++; $display("FAIL strict_valid1: got %0b want 1", sub_valid); end
        exp_item = exp_q.pop_front();
        checks++; if ({sub_player, sub_val} !== exp_item) begin errors++; $display("FAIL strict_data1: got p%0d v%0d want p%0d v%0d", sub_player, sub_val, exp_item[5:3], exp_item[2:0]); end
        @(negedge clk);
        checks++; if (turn !== 3'd2) begin errors++; $display("FAIL strict_turn2: got %0d want 2", turn); end
        checks++; if (pending !== 6'b0) begin errors++; $display("FAIL strict_pending_clr: got %b want 0", pending); end
    endtask

    task automatic test_backpressure();
        bit got;
        bit extra;
        do_reset();
        sub_ready = 1'b0;
        exp_q.push_back({3'd4, 3'd3});
        pulse(6'b010000, pv(4, 3'd3));
        wait_valid(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_grant_timeout: got %0b want 1", got); end
        pulse(6'b010000, pv(4, 3'd6));
        repeat (4) @(negedge clk);
        exp_item = exp_q.pop_front();
        checks++; if (sub_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %0b want 1", sub_valid); end
        checks++; if ({sub_player, sub_val} !== exp_item) begin errors++; $display("FAIL bp_stable: got p%0d v%0d want p%0d v%0d", sub_player, sub_val, exp_item[5:3], exp_item[2:0]); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %0b want 1", overrun); end
        sub_ready = 1'b1;
        @(negedge clk);
        checks++; if (sub_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b want 0", sub_valid); end
        extra = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sub_valid) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL bp_second_grant: got %0b want 0", extra); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_sticky: got %0b want 1", overrun); end
    endtask

    task automatic test_inactive_skip();
        bit got;
        do_reset();
        active_mask = 6'b101101;
        mode        = 1'b1;
        pulse(6'b000010, pv(1, 3'd4));
        repeat (4) @(negedge clk);
        checks++; if (pending !== 6'b0) begin errors++; $display("FAIL skip_ignored: got %b want 0", pending); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL skip_overrun: got %0b want 0", overrun); end
        exp_q.push_back({3'd0, 3'd1});
        pulse(6'b000001, pv(0, 3'd1));
        wait_valid(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL skip_grant_timeout: got %0b want 1", got); end
        exp_item = exp_q.pop_front();
        checks++; if ({sub_player, sub_val} !== exp_item) begin errors++; $display("FAIL skip_data: got p%0d v%0d want p%0d v%0d", sub_player, sub_val, exp_item[5:3], exp_item[2:0]); end
        @(negedge clk);
        checks++; if (turn !== 3'd2) begin errors++; $display("FAIL skip_turn: got %0d want 2", turn); end
    endtask

    task automatic test_reset_mid_grant();
        bit got;
        bit extra;
        do_reset();
        sub_ready = 1'b0;
        exp_q.push_back({3'd3, 3'd5});
        pulse(6'b001000, pv(3, 3'd5));
        wait_valid(20, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL rst_grant_timeout: got %0b want 1", got); end
        checks++; if (pending !== 6'b001000) begin errors++; $display("FAIL rst_pending_before: got %b want 001000", pending); end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++; if (sub_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", sub_valid); end
        checks++; if ({sub_player, sub_val} !== 6'd0) begin errors++; $display("FAIL rst_data: got p%0d v%0d want p0 v0", sub_player, sub_val); end
        checks++; if (pending !== 6'b0) begin errors++; $display("FAIL rst_pending: got %b want 0", pending); end
        reset     = 1'b0;
        sub_ready = 1'b1;
        extra     = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sub_valid) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL rst_no_grant: got %0b want 0", extra); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_strict();
        test_backpressure();
        test_inactive_skip();
        test_reset_mid_grant();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
